// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared types and helpers for the layer priority mux
package layer_pkg;

  localparam int MAX_LAYERS = 8;
  localparam int CH_W_DEF   = 4;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  // Flat bit position of ordered pair (i,j) in an n*n collision matrix.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/layer_pick.sv
// rtl/layer_pick.sv - lowest-index priority encoder over the effective draw vector
module layer_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eff_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] index_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    valid_o = |eff_i;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eff_i[i]) index_o = ($clog2(N))'(i);
    end
  end

endmodule

// File: rtl/layer_priority_mux.sv
// rtl/layer_priority_mux.sv - N-layer draw priority mux with live and per-frame collision flags
module layer_priority_mux
  import layer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int CH_W       = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frame_start,
  input  logic [NUM_LAYERS-1:0]                layer_en,
  input  logic [NUM_LAYERS-1:0]                draw_in,
  input  logic [NUM_LAYERS*3*CH_W-1:0]         rgb_in,
  input  logic [3*CH_W-1:0]                    rgb_bg,
  output logic [CH_W-1:0]                      Red_level,
  output logic [CH_W-1:0]                      Green_level,
  output logic [CH_W-1:0]                      Blue_level,
  output logic                                 drawn,
  output logic [$clog2(NUM_LAYERS)-1:0]        top_layer,
  output logic [NUM_LAYERS*NUM_LAYERS-1:0]     coll_live,
  output logic [NUM_LAYERS*NUM_LAYERS-1:0]     coll_frame,
  output logic                                 coll_valid
);

  localparam int N  = NUM_LAYERS;
  localparam int RW = 3 * CH_W;
  localparam int IW = $clog2(N);
  localparam int PW = N * N;

  if (N < 2 || N > MAX_LAYERS) begin : g_bad_layers
    $error("NUM_LAYERS out of range");
  end

  logic [N-1:0]    eff_q;
  logic [N*RW-1:0] rgb_q;
  logic [RW-1:0]   bg_q;
  logic            fs_q;

  logic [RW-1:0]   colour_q;
  logic            drawn_q;
  logic [IW-1:0]   top_q;
  logic [PW-1:0]   live_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   frame_q;
  logic            cvalid_q;

  logic [RW-1:0]   layer_rgb [N];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [RW-1:0]   colour_d;
  logic [PW-1:0]   live_d;
  logic [PW-1:0]   acc_d;

  for (genvar g = 0; g < N; g++) begin : g_split
    assign layer_rgb[g] = rgb_q[g*RW +: RW];
  end

  layer_pick #(.N(N)) u_pick (
    .eff_i   (eff_q),
    .valid_o (pick_valid),
    .index_o (pick_idx)
  );

  assign colour_d = pick_valid ? layer_rgb[pick_idx] : bg_q;

  always_comb begin
    live_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i != j) live_d[pair_idx(i, j, N)] = eff_q[i] & eff_q[j];
      end
    end
  end

  // The frame_start pixel opens the new frame, so its pairs seed the fresh accumulator.
  assign acc_d = fs_q ? live_d : (acc_q | live_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      eff_q    <= '0;
      rgb_q    <= '0;
      bg_q     <= '0;
      fs_q     <= 1'b0;
      colour_q <= '0;
      drawn_q  <= 1'b0;
      top_q    <= '0;
      live_q   <= '0;
      acc_q    <= '0;
      frame_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      eff_q    <= draw_in & layer_en;
      rgb_q    <= rgb_in;
      bg_q     <= rgb_bg;
      fs_q     <= frame_start;
      colour_q <= colour_d;
      drawn_q  <= pick_valid;
      top_q    <= pick_idx;
      live_q   <= live_d;
      acc_q    <= acc_d;
      cvalid_q <= fs_q;
      if (fs_q) frame_q <= acc_q;
    end
  end

  assign Red_level   = colour_q[3*CH_W-1 -: CH_W];
  assign Green_level = colour_q[2*CH_W-1 -: CH_W];
  assign Blue_level  = colour_q[CH_W-1   -: CH_W];
  assign drawn       = drawn_q;
  assign top_layer   = top_q;
  assign coll_live   = live_q;
  assign coll_frame  = frame_q;
  assign coll_valid  = cvalid_q;

endmodule

// File: tb/tb_layer_priority_mux.sv
// tb/tb_layer_priority_mux.sv - self-checking bench for layer_priority_mux
module tb_layer_priority_mux;
  import layer_pkg::*;

  localparam logic [47:0] COLS = {12'h00F, 12'h0F0, 12'hF00, 12'hAAA};
  localparam logic [11:0] BG   = 12'h123;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [3:0]  layer_en;
  logic [3:0]  draw_in;
  logic [47:0] rgb_in;
  logic [11:0] rgb_bg;
  logic [3:0]  Red_level, Green_level, Blue_level;
  logic        drawn;
  logic [1:0]  top_layer;
  logic [15:0] coll_live, coll_frame;
  logic        coll_valid;

  always #5 clk = ~clk;

  layer_priority_mux #(.NUM_LAYERS(4), .CH_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .layer_en    (layer_en),
    .draw_in     (draw_in),
    .rgb_in      (rgb_in),
    .rgb_bg      (rgb_bg),
    .Red_level   (Red_level),
    .Green_level (Green_level),
    .Blue_level  (Blue_level),
    .drawn       (drawn),
    .top_layer   (top_layer),
    .coll_live   (coll_live),
    .coll_frame  (coll_frame),
    .coll_valid  (coll_valid)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        drawn;
    logic [1:0]  top;
    logic [15:0] live;
    logic        chk_frame;
    logic [15:0] frame;
    logic        valid;
  } exp_t;

  typedef struct {
    logic        fs;
    logic [3:0]  en;
    logic [3:0]  draw;
    logic [11:0] bg;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    rgb_t got;
    got = {Red_level, Green_level, Blue_level};
    chk("rgb", 64'(got), 64'(e.rgb));
    chk("drawn", 64'(drawn), 64'(e.drawn));
    chk("top_layer", 64'(top_layer), 64'(e.top));
    chk("coll_live", 64'(coll_live), 64'(e.live));
    chk("coll_valid", 64'(coll_valid), 64'(e.valid));
    if (e.chk_frame) chk("coll_frame", 64'(coll_frame), 64'(e.frame));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    frame_start = v.fs;
    layer_en    = v.en;
    draw_in     = v.draw;
    rgb_bg      = v.bg;
    rgb_in      = COLS;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) compare(sb.pop_front());
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic [3:0] draw, input logic [11:0] bg,
                              input logic [11:0] rgb, input logic dr, input logic [1:0] top,
                              input logic [15:0] live);
    vec_t v;
    v.fs = 1'b0; v.en = en; v.draw = draw; v.bg = bg;
    v.e = '{rgb: rgb, drawn: dr, top: top, live: live, chk_frame: 1'b1, frame: 16'h0, valid: 1'b0};
    return v;
  endfunction

  // Hand-sequence pixel: colour and live pairs from a tiny reference, frame fields given explicitly.
  task automatic px(input logic fs, input logic [3:0] en, input logic [3:0] draw,
                    input logic [15:0] frame, input logic valid);
    vec_t        v;
    logic [3:0]  eff;
    logic [47:0] cols;
    cols = COLS;
    eff  = en & draw;
    v.fs = fs; v.en = en; v.draw = draw; v.bg = BG;
    v.e = '{rgb: BG, drawn: 1'b0, top: 2'd0, live: 16'h0, chk_frame: 1'b1, frame: frame, valid: valid};
    for (int i = 3; i >= 0; i--) begin
      if (eff[i]) begin
        v.e.rgb   = cols[i*12 +: 12];
        v.e.drawn = 1'b1;
        v.e.top   = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i != j) v.e.live[i*4+j] = eff[i] & eff[j];
    apply(v);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; frame_start = 1'b1; draw_in = 4'hF; layer_en = 4'hF;
    sb.delete();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("rst_rgb", 64'({Red_level, Green_level, Blue_level}), 64'h0);
      chk("rst_drawn", 64'(drawn), 64'h0);
      chk("rst_top", 64'(top_layer), 64'h0);
      chk("rst_live", 64'(coll_live), 64'h0);
      chk("rst_frame", 64'(coll_frame), 64'h0);
      chk("rst_valid", 64'(coll_valid), 64'h0);
    end
    @(negedge clk);
    reset = 1'b0; frame_start = 1'b0; draw_in = 4'h0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; layer_en = 4'h0; draw_in = 4'h0;
    rgb_in = COLS; rgb_bg = BG;

    tbl[0] = mk(4'hF, 4'b0000, 12'h123, 12'h123, 1'b0, 2'd0, 16'h0000);
    tbl[1] = mk(4'hF, 4'b1010, 12'h123, 12'hF00, 1'b1, 2'd1, 16'h2080);
    tbl[2] = mk(4'b1101, 4'b1010, 12'h123, 12'h00F, 1'b1, 2'd3, 16'h0000);
    tbl[3] = mk(4'h0, 4'b1111, 12'h456, 12'h456, 1'b0, 2'd0, 16'h0000);
    tbl[4] = mk(4'hF, 4'b0001, 12'h123, 12'hAAA, 1'b1, 2'd0, 16'h0000);
    tbl[5] = mk(4'b1000, 4'b1000, 12'h123, 12'h00F, 1'b1, 2'd3, 16'h0000);
    tbl[6] = mk(4'hF, 4'b1111, 12'h123, 12'hAAA, 1'b1, 2'd0, 16'h7BDE);

    do_reset(3);
    foreach (tbl[k]) apply(tbl[k]);

    // First publish carries the partial frame since reset; then frame/corner sequences.
    px(1'b1, 4'hF,    4'b0000, 16'h7BDE, 1'b1);
    px(1'b0, 4'hF,    4'b0101, 16'h7BDE, 1'b0);
    px(1'b1, 4'hF,    4'b1010, 16'h0104, 1'b1);
    px(1'b0, 4'hF,    4'b0000, 16'h0104, 1'b0);
    px(1'b1, 4'hF,    4'b0011, 16'h2080, 1'b1);
    px(1'b1, 4'hF,    4'b0000, 16'h0012, 1'b1);
    px(1'b0, 4'hF,    4'b0101, 16'h0012, 1'b0);
    px(1'b0, 4'b1110, 4'b0101, 16'h0012, 1'b0);
    px(1'b1, 4'hF,    4'b0000, 16'h0104, 1'b1);
    px(1'b0, 4'hF,    4'b0110, 16'h0104, 1'b0);

    do_reset(1);
    px(1'b0, 4'hF, 4'b1100, 16'h0000, 1'b0);
    px(1'b1, 4'hF, 4'b0000, 16'h4800, 1'b1);
    px(1'b0, 4'hF, 4'b0000, 16'h4800, 1'b0);
    px(1'b0, 4'hF, 4'b0000, 16'h4800, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
